// File: rtl/fft_reg_out_if.sv
// rtl/fft_reg_out_if.sv - handshake bundle between the butterfly datapath, the result register and its consumer
//
// Signals (directions as seen by the result register, modport slave):
//   clear      in   synchronous abort of the frame being collected
//   in_valid   in   in_data holds a butterfly result word
//   in_ready   out  register accepts a word this cycle
//   in_data    in   result word, component 0 in the low data_width bits
//   wr_slot    out  slot the next accepted word will occupy
//   out_valid  out  a complete frame is on out_data
//   out_ready  in   consumer takes the frame
//   out_data   out  packed frame, slot k at [(k+1)*SW-1 : k*SW]
//   frame_cnt  out  delivered-frame counter, wraps 255->0
interface fft_reg_out_if #(
  parameter int NO_comp_word = 2,
  parameter int data_width   = 8
);
  localparam int NUM_SLOTS = 2 ** NO_comp_word;
  localparam int SW        = NO_comp_word * data_width;

  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic [SW-1:0]           in_data;
  logic [NO_comp_word-1:0] wr_slot;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_SLOTS*SW-1:0] out_data;
  logic [7:0]              frame_cnt;

  // Producer/consumer side: drives words, clear and out_ready.
  modport master (
    output clear,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  wr_slot,
    input  out_valid,
    input  out_data,
    input  frame_cnt
  );

  // Result register side.
  modport slave (
    input  clear,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output wr_slot,
    output out_valid,
    output out_data,
    output frame_cnt
  );
endinterface

// File: rtl/fft_reg_out.sv
// rtl/fft_reg_out.sv - collects butterfly result words into slots and hands the full frame downstream
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   fft_reg_out_if.slave: in_valid/in_ready/in_data word input, wr_slot,
//         out_valid/out_ready/out_data frame output, frame_cnt, clear
//
// Two states: FILL accepts one word per handshake into slot wr_slot; the word
// landing in the last slot moves to HOLD, where the frame is offered until the
// consumer takes it. Handshake outputs are decoded from the registered state
// only, so there is no combinational path from in_valid/out_ready to outputs.
module fft_reg_out #(
  parameter int NO_comp_word = 2,
  parameter int data_width   = 8
) (
  input  logic          clk,
  input  logic          rst,
  fft_reg_out_if.slave  bus
);

  localparam int NUM_SLOTS = 2 ** NO_comp_word;
  localparam int SW        = NO_comp_word * data_width;

  localparam logic [NO_comp_word-1:0] SLOT_LAST = NO_comp_word'(NUM_SLOTS - 1);
  localparam logic [NO_comp_word-1:0] SLOT_STEP = NO_comp_word'(1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                  state_q,     state_d;
  logic [NO_comp_word-1:0] wr_slot_q,   wr_slot_d;
  logic [7:0]              frame_cnt_q, frame_cnt_d;
  logic [SW-1:0]           slot_q [NUM_SLOTS];
  logic [SW-1:0]           slot_d [NUM_SLOTS];

  logic accept;
  logic deliver;

  assign accept  = bus.in_valid  && (state_q == FILL);
  assign deliver = bus.out_ready && (state_q == HOLD);

  // Priority: clear discards everything in flight (including an output
  // handshake, which then does not count), then input accept, then delivery.
  // accept and deliver are mutually exclusive by state.
  always_comb begin
    state_d     = state_q;
    wr_slot_d   = wr_slot_q;
    frame_cnt_d = frame_cnt_q;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_d[k] = slot_q[k];
    end

    if (bus.clear) begin
      state_d   = FILL;
      wr_slot_d = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_d[k] = '0;
      end
    end else if (accept) begin
      slot_d[wr_slot_q] = bus.in_data;
      // Natural wrap of the slot index brings wr_slot back to 0 on the last word.
      wr_slot_d = wr_slot_q + SLOT_STEP;
      if (wr_slot_q == SLOT_LAST) begin
        state_d = HOLD;
      end
    end else if (deliver) begin
      // Slots are deliberately left intact; the next frame overwrites them
      // one by one, and out_valid tells the consumer when they are meaningful.
      state_d     = FILL;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wr_slot_q   <= '0;
      frame_cnt_q <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_slot_q   <= wr_slot_d;
      frame_cnt_q <= frame_cnt_d;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.wr_slot   = wr_slot_q;
  assign bus.frame_cnt = frame_cnt_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bus.out_data[g*SW +: SW] = slot_q[g];
  end

endmodule
